gate_toggle_monitor: RTL and testbench

- Downstream observation stage for a standard-cell gate under power test, such as a 3-input AND driven by pattern logic.
- Samples the gate output Q over a programmable window of CLK cycles.
- Counts rising transitions, falling transitions and high cycles, which give toggle rate and duty for switching-power correlation.
- Returns results through a valid/ready handshake to the test controller.

---
 rtl/gate_toggle_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_gate_toggle_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_toggle_monitor.sv
// gate_toggle_monitor: counts rising, falling and high cycles of a gate
// output over a programmable window and returns the results over valid/ready.
module gate_toggle_monitor #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned WIN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW_LEN,
  input  logic             Q_IN,
  output logic             BUSY,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] FALL_CNT,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic             OVF,
  output logic             RES_VALID,
  input  logic             RES_READY
);

  // Settle counter only needs to reach SYNC_STAGES (at most 3).
  localparam int unsigned     SET_W   = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_start_acc;
  logic               w_abort_clr;
  logic               w_count_en;
  logic               w_settle_en;

  logic               w_s;
  logic               r_prev;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [WIN_W-1:0]   r_win_len;
  logic [WIN_W-1:0]   r_win_cnt;

  logic [CNT_W-1:0]   r_rise;
  logic [CNT_W-1:0]   r_fall;
  logic [CNT_W-1:0]   r_high;
  logic               r_ovf;
  logic               r_busy;
  logic               r_valid;

  logic               w_rise_hit;
  logic               w_fall_hit;
  logic               w_high_hit;
  logic               w_sat;

  // Input synchronizer; zero stages means Q_IN is sampled directly.
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign w_s = Q_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;

      // Shift Q_IN through the synchronizer chain, oldest sample at the top.
      always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
          r_sync <= '0;
        end else begin
          r_sync <= SYNC_STAGES'({r_sync, Q_IN});
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Previous-sample register for edge detection; tracks s every cycle.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_s;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_abort_clr = 1'b0;
    w_count_en  = 1'b0;
    w_settle_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (START && !ABORT && (WINDOW_LEN != '0)) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (ABORT) begin
          w_abort_clr = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_settle_en = 1'b1;
          if (r_settle_cnt == SET_W'(SYNC_STAGES)) begin
            w_state_nxt = S_COUNT;
          end
        end
      end
      S_COUNT: begin
        if (ABORT) begin
          w_abort_clr = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_en = 1'b1;
          if (r_win_cnt == (r_win_len - WIN_W'(1))) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Result is presented in every DONE cycle, so READY alone completes it.
        if (RES_READY) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Window length latch plus settle and window position counters.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_win_len    <= '0;
      r_win_cnt    <= '0;
      r_settle_cnt <= '0;
    end else begin
      if (w_start_acc) begin
        r_win_len    <= WINDOW_LEN;
        r_win_cnt    <= '0;
        r_settle_cnt <= '0;
      end else begin
        if (w_settle_en) begin
          r_settle_cnt <= r_settle_cnt + SET_W'(1);
        end
        if (w_count_en) begin
          r_win_cnt <= r_win_cnt + WIN_W'(1);
        end
      end
    end
  end

  // Event detection for the current counted cycle.
  always_comb begin
    w_rise_hit = w_count_en & ~r_prev &  w_s;
    w_fall_hit = w_count_en &  r_prev & ~w_s;
    w_high_hit = w_count_en &  w_s;
    w_sat      = (w_rise_hit && (r_rise == CNT_MAX)) ||
                 (w_fall_hit && (r_fall == CNT_MAX)) ||
                 (w_high_hit && (r_high == CNT_MAX));
  end

  // Saturating result counters and sticky overflow flag.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_rise <= '0;
      r_fall <= '0;
      r_high <= '0;
      r_ovf  <= 1'b0;
    end else if (w_start_acc || w_abort_clr) begin
      r_rise <= '0;
      r_fall <= '0;
      r_high <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_rise_hit && (r_rise != CNT_MAX)) begin
        r_rise <= r_rise + CNT_W'(1);
      end
      if (w_fall_hit && (r_fall != CNT_MAX)) begin
        r_fall <= r_fall + CNT_W'(1);
      end
      if (w_high_hit && (r_high != CNT_MAX)) begin
        r_high <= r_high + CNT_W'(1);
      end
      if (w_sat) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Registered status outputs derived from the upcoming state.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != S_IDLE);
      r_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign BUSY      = r_busy;
  assign RES_VALID = r_valid;
  assign RISE_CNT  = r_rise;
  assign FALL_CNT  = r_fall;
  assign HIGH_CNT  = r_high;
  assign OVF       = r_ovf;

endmodule

// File: tb/tb_gate_toggle_monitor.sv
// Self-checking bench for gate_toggle_monitor with a sample-stream reference model.
module tb_gate_toggle_monitor;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned WIN_W       = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CMAX        = (1 << CNT_W) - 1;
  localparam int unsigned HIST        = 16384;

  logic             CLK = 1'b0;
  logic             RSTB = 1'b0;
  logic             START = 1'b0;
  logic             ABORT = 1'b0;
  logic [WIN_W-1:0] WINDOW_LEN = '0;
  logic             Q_IN = 1'b0;
  logic             RES_READY = 1'b0;
  logic             BUSY;
  logic [CNT_W-1:0] RISE_CNT;
  logic [CNT_W-1:0] FALL_CNT;
  logic [CNT_W-1:0] HIGH_CNT;
  logic             OVF;
  logic             RES_VALID;

  int n_tests = 0;
  int n_fail  = 0;

  gate_toggle_monitor #(
    .CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(CLK), .RSTB(RSTB), .START(START), .ABORT(ABORT),
    .WINDOW_LEN(WINDOW_LEN), .Q_IN(Q_IN), .BUSY(BUSY),
    .RISE_CNT(RISE_CNT), .FALL_CNT(FALL_CNT), .HIGH_CNT(HIGH_CNT),
    .OVF(OVF), .RES_VALID(RES_VALID), .RES_READY(RES_READY)
  );

  always #5 CLK = ~CLK;

  // Record the Q_IN value present at every rising edge.
  int unsigned edge_n = 0;
  logic        qa [0:HIST-1];
  always @(posedge CLK) begin
    edge_n = edge_n + 1;
    if (edge_n < HIST) qa[edge_n] = Q_IN;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // mode 0: random, 1: constant high, 2: toggle, 3: constant low
  task automatic drive_q(input int mode);
    case (mode)
      1:       Q_IN = 1'b1;
      2:       Q_IN = ~Q_IN;
      3:       Q_IN = 1'b0;
      default: Q_IN = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_counts(input string tag, input int unsigned er, input int unsigned ef,
                              input int unsigned eh, input int unsigned eo);
    check_eq({tag, "_rise"}, 32'(RISE_CNT), er);
    check_eq({tag, "_fall"}, 32'(FALL_CNT), ef);
    check_eq({tag, "_high"}, 32'(HIGH_CNT), eh);
    check_eq({tag, "_ovf"},  32'(OVF), eo);
  endtask

  // One full measurement: start, wait for result, handshake, compare with model.
  task automatic run_meas(input int unsigned w, input int mode, input int unsigned hold,
                          input bit ready_early, input bit poke_start);
    int unsigned t, lat, er, ef, eh, eo;
    bit seen;
    logic s, p;
    drive_q(mode);
    WINDOW_LEN = WIN_W'(w);
    START = 1'b1;
    RES_READY = ready_early;
    tick();
    t = edge_n;
    START = 1'b0;
    WINDOW_LEN = WIN_W'($urandom);
    check_eq("busy_after_start", 32'(BUSY), 1);
    check_eq("clear_on_start", 32'({OVF, RISE_CNT, FALL_CNT, HIGH_CNT}), 0);
    seen = 1'b0;
    lat = 0;
    for (int unsigned k = 1; k <= w + SYNC_STAGES + 8 && !seen; k++) begin
      drive_q(mode);
      if (poke_start && k == SYNC_STAGES + 3) begin
        START = 1'b1;
        WINDOW_LEN = WIN_W'(1);
      end else begin
        START = 1'b0;
      end
      tick();
      if (RES_VALID) begin
        seen = 1'b1;
        lat = k;
      end
    end
    START = 1'b0;
    check_eq("latency", seen ? lat : 0, SYNC_STAGES + 1 + w);
    if (!seen) return;

    // Sample seen at edge m is Q_IN from edge m-SYNC_STAGES; window follows SETTLE.
    er = 0; ef = 0; eh = 0; eo = 0;
    for (int unsigned m = t + SYNC_STAGES + 2; m <= t + SYNC_STAGES + w + 1; m++) begin
      s = qa[m - SYNC_STAGES];
      p = qa[m - 1 - SYNC_STAGES];
      if (!p && s) begin if (er == CMAX) eo = 1; else er++; end
      if (p && !s) begin if (ef == CMAX) eo = 1; else ef++; end
      if (s)       begin if (eh == CMAX) eo = 1; else eh++; end
    end
    check_counts("result", er, ef, eh, eo);
    if (!OVF) check_eq("rise_fall_balance", 32'((RISE_CNT > FALL_CNT ? RISE_CNT - FALL_CNT
                                                  : FALL_CNT - RISE_CNT) <= 1), 1);

    if (ready_early) begin
      drive_q(0);
      tick();
      check_eq("valid_one_cycle", 32'(RES_VALID), 0);
    end else begin
      for (int unsigned h = 0; h < hold; h++) begin
        drive_q(0);
        tick();
        check_eq("hold_valid", 32'(RES_VALID), 1);
        check_counts("hold", er, ef, eh, eo);
      end
      RES_READY = 1'b1;
      drive_q(0);
      tick();
      check_eq("valid_after_xfer", 32'(RES_VALID), 0);
    end
    RES_READY = 1'b0;
    check_eq("idle_after_xfer", 32'(BUSY), 0);
    drive_q(0);
    tick();
    check_counts("held_in_idle", er, ef, eh, eo);
  endtask

  // Abort a measurement `pre` cycles after the accepted START.
  task automatic run_abort(input int unsigned w, input int unsigned pre);
    bit seen;
    drive_q(2);
    WINDOW_LEN = WIN_W'(w);
    START = 1'b1;
    RES_READY = 1'b0;
    tick();
    START = 1'b0;
    repeat (pre) begin drive_q(2); tick(); end
    ABORT = 1'b1;
    drive_q(2);
    tick();
    ABORT = 1'b0;
    check_eq("abort_busy", 32'(BUSY), 0);
    check_eq("abort_clear", 32'({OVF, RISE_CNT, FALL_CNT, HIGH_CNT}), 0);
    seen = 1'b0;
    repeat (w + 8) begin drive_q(0); tick(); if (RES_VALID) seen = 1'b1; end
    check_eq("abort_no_valid", 32'(seen), 0);
  endtask

  // Pulse START in IDLE with a given ABORT/WINDOW_LEN and expect no measurement.
  task automatic run_ignored_start(input string tag, input int unsigned w, input logic ab);
    bit seen;
    WINDOW_LEN = WIN_W'(w);
    START = 1'b1;
    ABORT = ab;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    check_eq(tag, 32'(BUSY), 0);
    seen = 1'b0;
    repeat (w + SYNC_STAGES + 4) begin tick(); if (BUSY || RES_VALID) seen = 1'b1; end
    check_eq({tag, "_quiet"}, 32'(seen), 0);
  endtask

  initial begin
    bit seen;
    repeat (3) tick();
    check_eq("reset_outputs", 32'({BUSY, RES_VALID, OVF, RISE_CNT, FALL_CNT, HIGH_CNT}), 0);
    RSTB = 1'b1;
    repeat (4) tick();

    run_meas(10, 1, 0, 1'b1, 1'b0);
    run_meas(8, 2, 5, 1'b0, 1'b0);
    run_meas(40, 1, 2, 1'b0, 1'b0);
    run_meas(5, 0, 1, 1'b0, 1'b0);
    run_meas(12, 0, 0, 1'b0, 1'b1);

    run_abort(20, SYNC_STAGES + 1 + 3);
    run_abort(12, 1);
    run_ignored_start("start_abort_idle", 5, 1'b1);
    run_ignored_start("start_len_zero", 0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      int unsigned w;
      w = $urandom_range(1, 24);
      run_meas(w, int'($urandom_range(0, 5)) % 4, $urandom_range(0, 5),
               1'($urandom_range(0, 1)), (w >= 3) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Asynchronous reset in the middle of a counting window.
    drive_q(2);
    WINDOW_LEN = WIN_W'(30);
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (SYNC_STAGES + 1 + 4) begin drive_q(2); tick(); end
    #2;
    RSTB = 1'b0;
    #1;
    check_eq("reset_mid_count", 32'({BUSY, RES_VALID, OVF, RISE_CNT, FALL_CNT, HIGH_CNT}), 0);
    repeat (2) begin drive_q(2); tick(); end
    RSTB = 1'b1;
    seen = 1'b0;
    repeat (40) begin drive_q(2); tick(); if (RES_VALID || BUSY) seen = 1'b1; end
    check_eq("no_result_after_reset", 32'(seen), 0);

    run_meas(9, 0, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
